// File: rtl/cic_decimator_n.sv
// N-order CIC decimator for a 1-bit unsigned bitstream with a runtime ratio,
// output right-shift and a 2-entry valid/ready output FIFO with sticky overrun.
module cic_decimator_n #(
    parameter int ORDER          = 2,
    parameter int MAX_DECIMATION = 64,
    parameter int REGISTER_WIDTH = 25,
    parameter int OUT_WIDTH      = 16,
    localparam int DW            = $clog2(MAX_DECIMATION + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 modulator_data_i,
    input  logic [DW-1:0]        decimation_i,
    input  logic [4:0]           shift_i,
    input  logic                 clear_overrun_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 tick_o,
    output logic                 overrun_o,
    output logic [DW-1:0]        phase_o
);

    localparam int RW = REGISTER_WIDTH;

    if (ORDER < 1 || ORDER > 4) begin : g_order_chk
        $error("cic_decimator_n: ORDER must be within 1..4");
    end
    if (REGISTER_WIDTH < ORDER * $clog2(MAX_DECIMATION) + 1) begin : g_rw_chk
        $error("cic_decimator_n: REGISTER_WIDTH too small for ORDER and MAX_DECIMATION");
    end
    if (OUT_WIDTH > REGISTER_WIDTH) begin : g_ow_chk
        $error("cic_decimator_n: OUT_WIDTH must not exceed REGISTER_WIDTH");
    end

    logic [ORDER-1:0][RW-1:0] integ_q, integ_d;
    logic [ORDER-1:0][RW-1:0] dly_q, dly_d;
    logic [ORDER-1:0][RW-1:0] comb_c;
    logic [DW-1:0]            phase_q, phase_d;
    logic [DW-1:0]            r_act_q, r_act_d;
    logic [DW-1:0]            r_req, r_eff;
    logic                     first_q, first_d;
    logic                     tick;
    logic [RW-1:0]            y_full;
    logic [1:0][OUT_WIDTH-1:0] mem_q, mem_d;
    logic                     wr_q, wr_d, rd_q, rd_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     ovr_q, ovr_d;
    logic                     push, pop, full;

    always_comb begin
        r_req = decimation_i;
        if (decimation_i < DW'(2))
            r_req = DW'(2);
        else if (decimation_i > DW'(MAX_DECIMATION))
            r_req = DW'(MAX_DECIMATION);
    end

    // The first cycle after reset release uses the live request, which is
    // also what gets latched, so R_act tracks the value seen at release.
    assign r_eff = first_q ? r_req : r_act_q;
    assign tick  = en_i && (phase_q == r_eff - DW'(1));

    always_comb begin
        phase_d = phase_q;
        r_act_d = r_act_q;
        first_d = 1'b0;
        if (en_i)
            phase_d = tick ? '0 : phase_q + DW'(1);
        if (tick || first_q)
            r_act_d = r_req;
    end

    always_comb begin
        integ_d = integ_q;
        if (en_i) begin
            integ_d[0] = integ_q[0] + {{(RW-1){1'b0}}, modulator_data_i};
            for (int k = 1; k < ORDER; k++)
                integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    // Comb chain sees the last integrator before this cycle's update.
    always_comb begin
        comb_c    = '0;
        dly_d     = dly_q;
        comb_c[0] = integ_q[ORDER-1] - dly_q[0];
        for (int k = 1; k < ORDER; k++)
            comb_c[k] = comb_c[k-1] - dly_q[k];
        if (tick) begin
            dly_d[0] = integ_q[ORDER-1];
            for (int k = 1; k < ORDER; k++)
                dly_d[k] = comb_c[k-1];
        end
    end

    assign y_full = comb_c[ORDER-1] >> shift_i;

    assign push = tick;
    assign pop  = valid_o && ready_i;
    assign full = (cnt_q == 2'd2);

    // When full, wr_q == rd_q: a simultaneous pop frees the slot being written.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (clear_overrun_i)
            ovr_d = 1'b0;
        if (pop) begin
            rd_d  = ~rd_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push) begin
            if (!full || pop) begin
                mem_d[wr_q] = y_full[OUT_WIDTH-1:0];
                wr_d        = ~wr_q;
                cnt_d       = cnt_d + 2'd1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            integ_q <= '0;
            dly_q   <= '0;
            phase_q <= '0;
            r_act_q <= DW'(2);
            first_q <= 1'b1;
            mem_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            phase_q <= phase_d;
            r_act_q <= r_act_d;
            first_q <= first_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign valid_o   = (cnt_q != 2'd0);
    assign data_o    = valid_o ? mem_q[rd_q] : '0;
    assign tick_o    = tick;
    assign overrun_o = ovr_q;
    assign phase_o   = phase_q;

endmodule

// File: doc/cic_decimator_n.md
# cic_decimator_n

Parametrised N-order CIC decimator for a 1-bit sigma-delta bitstream. It has a runtime-programmable decimation ratio, an output shift, and a 2-entry output FIFO with a valid/ready handshake. It sits between the modulator input pin and downstream consumers: the debug mux, a future serial readout or a further FIR stage. It generalises the fixed first- and second-order CIC instances to any order of 1 to 4.

## Interface
Parameters:
- ORDER, default 2: number of integrator and comb stages; legal range 1..4.
- MAX_DECIMATION, default 64: largest decimation ratio; DW = $clog2(MAX_DECIMATION+1).
- REGISTER_WIDTH, default 25: width of every integrator and comb register. An elaboration assertion requires REGISTER_WIDTH >= ORDER*$clog2(MAX_DECIMATION)+1.
- OUT_WIDTH, default 16: output sample width; must be <= REGISTER_WIDTH.

Ports:
- clk_i, in, 1: single clock.
- rst_i, in, 1: asynchronous, active-high reset.
- en_i, in, 1: when low, integrators, phase counter and combs hold; the FIFO keeps draining.
- modulator_data_i, in, 1: bitstream; 1 contributes +1 and 0 contributes 0 (unsigned).
- decimation_i, in, DW: requested ratio R.
- shift_i, in, 5: right shift applied to the comb result before truncation.
- clear_overrun_i, in, 1: clears the sticky overrun flag.
- data_o, out, OUT_WIDTH: FIFO head sample.
- valid_o, out, 1: FIFO non-empty.
- ready_i, in, 1: consumer accept; a pop occurs when valid_o & ready_i.
- tick_o, out, 1: one-cycle pulse on each decimation instant; this is the cic_clk equivalent.
- overrun_o, out, 1: sticky flag, set when a sample is dropped.
- phase_o, out, DW: current phase counter, for debug.

## Operation
- Integrators, per enabled cycle: integ[0] <= integ[0] + modulator_data_i; integ[k] <= integ[k] + integ[k-1] (registered, pipelined). All arithmetic is modulo 2^REGISTER_WIDTH; wrap-around is intended and never saturates.
- Phase counter:
  - Counts 0..R_act-1 on enabled cycles.
  - The tick cycle is any enabled cycle with phase == R_act-1; on it the counter returns to 0.
- Ratio latch:
  - R_act is loaded from decimation_i on each tick cycle and at reset release, so a mid-frame change takes effect from the next frame only.
  - Values below 2 are clamped to 2; values above MAX_DECIMATION are clamped to MAX_DECIMATION.
- Combs, evaluated only on tick cycles:
  - The input is the current register value integ[ORDER-1], before this cycle's update.
  - c[0] = in - d[0]; c[k] = c[k-1] - d[k].
  - Delay update: d[0] <= in; d[k] <= c[k-1].
- Output scaling: y = (c[ORDER-1] >> shift_i), keeping the low OUT_WIDTH bits. A shift_i beyond REGISTER_WIDTH gives 0.
- FIFO (2 entries):
  - On a tick it pushes y.
  - A push and a pop in the same cycle are both honoured, even when the FIFO is full.
  - Push while full with no pop: the new sample is dropped, the FIFO is unchanged and overrun_o is set.
- overrun_o clears on clear_overrun_i. If a set and a clear occur in the same cycle, set wins.
- en_i low on what would be a tick cycle: no tick and no push.

## Timing
- Reset values: all integrators, combs, delays, phase and FIFO pointers are 0. valid_o=0, data_o=0, tick_o=0, overrun_o=0, phase_o=0, R_act = clamp(decimation_i) sampled at reset release.
- rst_i asserted mid-frame or with the FIFO full: everything returns to reset values immediately (asynchronous). Pending samples are lost.
- tick_o is combinational with the tick cycle t. The sample is pushed at the end of t, and valid_o/data_o reflect it from cycle t+1, giving 1-cycle latency.
- data_o is stable while valid_o=1 and ready_i=0.
- Throughput: one sample per R_act enabled cycles. R_act >= 2 guarantees the FIFO can be drained continuously with ready_i held at 1.

## Test plan
- ORDER=1, R=10, shift=0, constant 1s, ready=1: first tick at cycle 9 outputs 9, then 10 on every subsequent sample; tick_o pulses every 10 cycles.
- ORDER=2, R=10, constant 1s: outputs settle to 100 from the third sample onward. With a 50% duty input (1010…), steady state is 50; with shift=2, 100 becomes 25.
- Overrun: ready=0 across 3 ticks:
  - The first two samples are held in order, the third is dropped and overrun_o=1.
  - Raising ready pops both in 2 cycles.
  - clear_overrun_i then clears the flag; a clear coincident with a drop leaves it at 1.
- Ratio change: write decimation_i 10→4 at phase 3. The current frame still ends at phase 9, and the next tick follows 4 cycles later. Writing 0 or 1 gives R_act=2; writing 200 with MAX=64 gives R_act=64.
- en_i low for 5 cycles mid-frame: phase and integrators hold, the tick is delayed by exactly 5 cycles, and output values match the un-gated run.
- Wrap: ORDER=4, R=64, minimum REGISTER_WIDTH, run constant 1s for ≥10^5 cycles: outputs stay at 64^4 mod 2^25 = 2^24, with no corruption from integrator wrap. Assert rst_i with the FIFO full: valid_o=0 immediately and all state is 0.
